// File: rtl/rapids_mem_pkg.sv
// Shared definitions for the memory path: arbiter state and owner encodings,
// default memory window, and the address translation used by the arbiter and MMU.
package rapids_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Default memory window: words [MEM_BASE_DEFAULT, MEM_BASE_DEFAULT+MEM_WORDS_DEFAULT-1]
  localparam int unsigned MEM_BASE_DEFAULT  = 16;
  localparam int unsigned MEM_WORDS_DEFAULT = 128;

  // Core word address -> backing memory word address
  function automatic logic [31:0] to_mem_addr(input logic [31:0] addr, input int unsigned base);
    return addr - 32'(base);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the memory-side port of the arbiter.
//
// Handshake semantics (all ports):
//   Core side: a requester raises *_req with its address/control/data stable and
//   holds them until the arbiter pulses *_done for exactly one cycle; *_fault and
//   *_rdata are only meaningful in that cycle. The requester drops *_req the cycle
//   after *_done; a req still high then is a new request.
//   Memory side: the arbiter raises m_req with m_we/m_addr/m_wdata stable and holds
//   them until m_ack is seen high at a rising edge; m_rdata is sampled in that cycle.
//   The arbiter may withdraw m_req without an ack only on timeout or reset.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic        i_fault;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic        d_fault;
  logic [31:0] d_rdata;

  logic        wait_instr;
  logic        wait_data;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_done, i_fault, i_rdata, d_done, d_fault, d_rdata,
           wait_instr, wait_data, m_req, m_we, m_addr, m_wdata
  );

  // Core + memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_done, i_fault, i_rdata, d_done, d_fault, d_rdata,
           wait_instr, wait_data, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_range_check.sv
// Combinational check that a 32-bit word address lies inside the memory window.
// Compare is done at 33 bits so BASE+WORDS never wraps; 0xFFFFFFFF is out of range.
module mem_range_check
  import rapids_mem_pkg::*;
#(
  parameter int unsigned BASE  = MEM_BASE_DEFAULT,
  parameter int unsigned WORDS = MEM_WORDS_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        in_range
);
  localparam logic [32:0] LO = 33'(BASE);
  localparam logic [32:0] HI = 33'(BASE) + 33'(WORDS);

  logic [32:0] addr_x;

  assign addr_x   = {1'b0, addr};
  assign in_range = (addr_x >= LO) && (addr_x < HI);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports of the core.
// Data has fixed priority, except that after MAX_STREAK consecutive data grants
// with a fetch pending the fetch port wins once. Out-of-range requests complete
// with a fault without touching memory; a memory that never acks is abandoned
// after TIMEOUT cycles with a fault. MAX_STREAK and TIMEOUT must be >= 1.
module mem_port_arbiter
  import rapids_mem_pkg::*;
#(
  parameter int unsigned MEM_BASE   = MEM_BASE_DEFAULT,
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int unsigned MAX_STREAK = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus,
  output arb_state_e         dbg_state
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   timer_q, timer_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic            win_d;
  logic            win_i;
  logic [31:0]     sel_addr;
  logic            sel_in_range;
  logic            resp;

  // Arbitration: data wins unless a fetch has been passed over MAX_STREAK times
  assign win_d    = bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX));
  assign win_i    = !win_d && bus.i_req;
  assign sel_addr = win_d ? bus.d_addr : bus.i_addr;

  mem_range_check #(
    .BASE  (MEM_BASE),
    .WORDS (MEM_WORDS)
  ) u_range (
    .addr     (sel_addr),
    .in_range (sel_in_range)
  );

  // Next-state, streak, timer and capture logic
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    owner_d  = owner_q;
    we_d     = we_q;
    m_addr_d = m_addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;

    case (state_q)
      ARB_IDLE: begin
        if (win_d || win_i) begin
          owner_d = win_d ? OWN_D : OWN_I;
          we_d    = win_d && bus.d_we;
          wdata_d = win_d ? bus.d_wdata : '0;
          rdata_d = '0;
          timer_d = '0;
          if (sel_in_range) begin
            m_addr_d = to_mem_addr(sel_addr, MEM_BASE);
            fault_d  = 1'b0;
            state_d  = ARB_ACCESS;
          end else begin
            m_addr_d = '0;
            fault_d  = 1'b1;
            state_d  = ARB_RESP;
          end
          if (win_i) begin
            streak_d = '0;
          end else if (bus.i_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      ARB_ACCESS: begin
        // An ack in the last timer cycle still counts as a normal completion
        if (bus.m_ack) begin
          rdata_d = we_q ? '0 : bus.m_rdata;
          fault_d = 1'b0;
          state_d = ARB_RESP;
        end else if (timer_q == TIMER_LAST) begin
          fault_d = 1'b1;
          state_d = ARB_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // A fetch that is not waiting owes nothing to the fairness counter
    if (!bus.i_req) begin
      streak_d = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Streak, timer and request/response capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
      timer_q  <= '0;
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      m_addr_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      streak_q <= streak_d;
      timer_q  <= timer_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      m_addr_q <= m_addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign resp = (state_q == ARB_RESP);

  // Core-side completion: only the owner sees done, data forced to 0 on fault/write
  assign bus.i_done  = resp && (owner_q == OWN_I);
  assign bus.d_done  = resp && (owner_q == OWN_D);
  assign bus.i_fault = bus.i_done && fault_q;
  assign bus.d_fault = bus.d_done && fault_q;
  assign bus.i_rdata = (bus.i_done && !fault_q) ? rdata_q : '0;
  assign bus.d_rdata = (bus.d_done && !fault_q && !we_q) ? rdata_q : '0;

  assign bus.wait_instr = bus.i_req && !bus.i_done;
  assign bus.wait_data  = bus.d_req && !bus.d_done;

  // m_req is decoded from state so an async reset withdraws it immediately
  assign bus.m_req   = (state_q == ARB_ACCESS);
  assign bus.m_we    = we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = wdata_q;

  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, read/write latency, range faults,
// starvation limit, ack timeout and reset during an access.
module tb_mem_port_arbiter;
  import rapids_mem_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_e dbg_state;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Expected grant owners (1 = data, 0 = fetch)
  logic [0:0] exp_q[$];

  // Memory model controls: 0 never ack, 1 ack on first m_req cycle, 2 ack on cycle ack_at
  int          ack_mode = 0;
  int          ack_at = 0;
  int          req_cycles = 0;
  logic [31:0] mem_rdata = 32'h0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder (drives on the falling edge) ----------------
  initial begin
    bus.m_ack   = 1'b0;
    bus.m_rdata = 32'h0;
  end
  always @(negedge clk) begin
    if (bus.m_req) req_cycles = req_cycles + 1;
    else           req_cycles = 0;
    bus.m_ack   = bus.m_req && ((ack_mode == 1) || ((ack_mode == 2) && (req_cycles == ack_at)));
    bus.m_rdata = bus.m_ack ? mem_rdata : 32'h0;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic drive_i(input logic req, input logic [31:0] addr);
    bus.i_req  = req;
    bus.i_addr = addr;
  endtask

  // Waits (bounded) for a done pulse; returns sampled #1 after the edge that raised it
  task automatic wait_done(input string tag, output logic got_i, output logic got_d);
    got_i = 1'b0;
    got_d = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.i_done || bus.d_done) begin
        got_i = bus.i_done;
        got_d = bus.d_done;
        return;
      end
    end
    check({tag, "_bound"}, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        gi, gd;
    int          mreq_cnt;
    logic [31:0] fault_addrs [4];

    fault_addrs[0] = 32'h0000_0000;
    fault_addrs[1] = 32'h0000_000F;
    fault_addrs[2] = 32'h0000_0090;
    fault_addrs[3] = 32'hFFFF_FFFF;

    // 1: reset with both requests high, then data is granted first
    rst_n = 1'b0;
    drive_d(1'b1, 1'b0, 32'h20, 32'h0);
    drive_i(1'b1, 32'h30);
    repeat (3) step();
    check("rst_i_done",  32'(bus.i_done),  32'd0);
    check("rst_d_done",  32'(bus.d_done),  32'd0);
    check("rst_m_req",   32'(bus.m_req),   32'd0);
    check("rst_m_addr",  bus.m_addr,       32'd0);
    check("rst_d_rdata", bus.d_rdata,      32'd0);
    check("rst_state",   32'(dbg_state),   32'(ARB_IDLE));
    rst_n = 1'b1;
    step();
    check("rst_first_grant_state", 32'(dbg_state), 32'(ARB_ACCESS));
    check("rst_first_grant_maddr", bus.m_addr, 32'h10);
    check("rst_first_grant_mwe",   32'(bus.m_we), 32'd0);
    // drop both mid-access: access still completes and pulses done
    drive_d(1'b0, 1'b0, 32'h20, 32'h0);
    drive_i(1'b0, 32'h30);
    ack_mode  = 1;
    mem_rdata = 32'hA5A5_0001;
    wait_done("rst_drop", gi, gd);
    check("rst_drop_d_done", 32'(gd), 32'd1);
    check("rst_drop_i_done", 32'(gi), 32'd0);
    check("rst_drop_rdata",  bus.d_rdata, 32'hA5A5_0001);
    step();

    // 2: data read, ack in the first m_req cycle, done 3 cycles after req-high
    mem_rdata = 32'hDEAD_BEEF;
    drive_d(1'b1, 1'b0, 32'h20, 32'h0);
    step();
    check("rd_cyc1_done",  32'(bus.d_done), 32'd0);
    check("rd_cyc1_mreq",  32'(bus.m_req), 32'd1);
    check("rd_cyc1_maddr", bus.m_addr, 32'h10);
    check("rd_cyc1_wait",  32'(bus.wait_data), 32'd1);
    step();
    check("rd_done",       32'(bus.d_done), 32'd1);
    check("rd_rdata",      bus.d_rdata, 32'hDEAD_BEEF);
    check("rd_fault",      32'(bus.d_fault), 32'd0);
    check("rd_i_done",     32'(bus.i_done), 32'd0);
    check("rd_wait_off",   32'(bus.wait_data), 32'd0);
    drive_d(1'b0, 1'b0, 32'h20, 32'h0);
    step();
    check("rd_one_pulse",  32'(bus.d_done), 32'd0);

    // 2b: write to the last valid word
    drive_d(1'b1, 1'b1, 32'h8F, 32'hCAFE_0042);
    step();
    check("wr_mwe",    32'(bus.m_we), 32'd1);
    check("wr_maddr",  bus.m_addr, 32'h7F);
    check("wr_mwdata", bus.m_wdata, 32'hCAFE_0042);
    step();
    check("wr_done",   32'(bus.d_done), 32'd1);
    check("wr_fault",  32'(bus.d_fault), 32'd0);
    check("wr_rdata",  bus.d_rdata, 32'd0);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // 3: out-of-range addresses fault after 2 cycles with no memory access
    foreach (fault_addrs[k]) begin
      drive_d(1'b1, 1'b1, fault_addrs[k], 32'h1111_2222);
      step();
      check($sformatf("dfault%0d_done",  k), 32'(bus.d_done), 32'd1);
      check($sformatf("dfault%0d_fault", k), 32'(bus.d_fault), 32'd1);
      check($sformatf("dfault%0d_mreq",  k), 32'(bus.m_req), 32'd0);
      drive_d(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check($sformatf("dfault%0d_idle", k), 32'(dbg_state), 32'(ARB_IDLE));
    end
    drive_i(1'b1, 32'h90);
    step();
    check("ifault_done",   32'(bus.i_done), 32'd1);
    check("ifault_fault",  32'(bus.i_fault), 32'd1);
    check("ifault_rdata",  bus.i_rdata, 32'd0);
    check("ifault_d_done", 32'(bus.d_done), 32'd0);
    check("ifault_mreq",   32'(bus.m_req), 32'd0);
    drive_i(1'b0, 32'h0);
    step();

    // 4: starvation limit with both requests held
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    mem_rdata = 32'h0BAD_F00D;
    drive_d(1'b1, 1'b0, 32'h20, 32'h0);
    drive_i(1'b1, 32'h40);
    for (int g = 0; g < 8; g++) begin
      logic [0:0] exp_own;
      wait_done($sformatf("starve%0d", g), gi, gd);
      exp_own = exp_q.pop_front();
      check($sformatf("starve%0d_owner", g), 32'(gd), 32'(exp_own));
      check($sformatf("starve%0d_single", g), 32'(gi ^ gd), 32'd1);
      if (g == 7) begin
        drive_d(1'b0, 1'b0, 32'h0, 32'h0);
        drive_i(1'b0, 32'h0);
      end
    end
    check("starve_i_rdata", bus.i_rdata, 32'h0BAD_F00D);
    step();

    // 5a: no ack -> m_req for exactly TIMEOUT cycles, then fault
    ack_mode = 2;
    ack_at   = 1000;
    mem_rdata = 32'h5555_AAAA;
    drive_d(1'b1, 1'b0, 32'h25, 32'h0);
    mreq_cnt = 0;
    gd = 1'b0;
    for (int n = 0; n < 40 && !gd; n++) begin
      step();
      if (bus.m_req) mreq_cnt++;
      gd = bus.d_done;
    end
    check("tmo_done",   32'(gd), 32'd1);
    check("tmo_cycles", 32'(mreq_cnt), 32'd15);
    check("tmo_fault",  32'(bus.d_fault), 32'd1);
    check("tmo_rdata",  bus.d_rdata, 32'd0);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // 5b: ack on the 15th cycle wins over the timeout
    ack_at = 15;
    drive_d(1'b1, 1'b0, 32'h25, 32'h0);
    mreq_cnt = 0;
    gd = 1'b0;
    for (int n = 0; n < 40 && !gd; n++) begin
      step();
      if (bus.m_req) mreq_cnt++;
      gd = bus.d_done;
    end
    check("lateack_done",   32'(gd), 32'd1);
    check("lateack_cycles", 32'(mreq_cnt), 32'd15);
    check("lateack_fault",  32'(bus.d_fault), 32'd0);
    check("lateack_rdata",  bus.d_rdata, 32'h5555_AAAA);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // 6: reset during ACCESS drops m_req at once and discards the result
    ack_mode = 0;
    drive_d(1'b1, 1'b0, 32'h20, 32'h0);
    step();
    check("rstmid_mreq_before", 32'(bus.m_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_mreq_async", 32'(bus.m_req), 32'd0);
    check("rstmid_state",      32'(dbg_state), 32'(ARB_IDLE));
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("rstmid_no_done%0d", n), 32'(bus.d_done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    ack_mode  = 1;
    mem_rdata = 32'h1234_5678;
    drive_d(1'b1, 1'b0, 32'h21, 32'h0);
    wait_done("rstmid_after", gi, gd);
    check("rstmid_after_done",  32'(gd), 32'd1);
    check("rstmid_after_rdata", bus.d_rdata, 32'h1234_5678);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a wait is ever left unbounded
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
